// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sync RAM between a word writer and a word reader.
// Define ARB_WRITE_PRIORITY_EN for fixed write priority; default is round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RDVAL, ERR} state_t;
  state_t state, nxt_state;
  logic pick_wr, nxt_wr_ack, nxt_rd_valid, nxt_err, nxt_en, nxt_we;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_wdata, nxt_rd_data;
  logic wr_oor, rd_oor;
  assign wr_oor = 32'(wr_addr) >= 32'(MEM_DEPTH);
  assign rd_oor = 32'(rd_addr) >= 32'(MEM_DEPTH);
`ifdef ARB_WRITE_PRIORITY_EN
  assign pick_wr = wr_req;
`else
  logic lg_wr;
  assign pick_wr = wr_req & (~rd_req | ~lg_wr);
  always_ff @(posedge clk or negedge rst)
    if (!rst) lg_wr <= 1'b0;
    else if (state == IDLE && (wr_req || rd_req)) lg_wr <= pick_wr;
`endif
  always_comb begin
    nxt_state    = state;
    nxt_wr_ack   = 1'b0;
    nxt_rd_valid = 1'b0;
    nxt_err      = 1'b0;
    nxt_en       = 1'b0;
    nxt_we       = 1'b0;
    nxt_addr     = mem_addr;
    nxt_wdata    = mem_wdata;
    nxt_rd_data  = rd_data;
    case (state)
      IDLE:
        if (pick_wr) begin
          nxt_wr_ack = 1'b1;
          nxt_err    = wr_oor;
          nxt_state  = wr_oor ? ERR : WRITE;
          nxt_en     = ~wr_oor;
          nxt_we     = ~wr_oor;
          nxt_addr   = wr_oor ? mem_addr : wr_addr;
          nxt_wdata  = wr_oor ? mem_wdata : wr_data;
        end else if (rd_req) begin
          nxt_rd_valid = rd_oor;
          nxt_err      = rd_oor;
          nxt_rd_data  = rd_oor ? '0 : rd_data;
          nxt_state    = rd_oor ? ERR : READ;
          nxt_en       = ~rd_oor;
          nxt_addr     = rd_oor ? mem_addr : rd_addr;
        end
      READ: nxt_state = WAIT;
      WAIT: begin
        nxt_state    = RDVAL;
        nxt_rd_valid = 1'b1;
        nxt_rd_data  = mem_rdata;
      end
      default: nxt_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= nxt_state;
      wr_ack    <= nxt_wr_ack;
      rd_valid  <= nxt_rd_valid;
      rd_data   <= nxt_rd_data;
      err       <= nxt_err;
      busy      <= nxt_state != IDLE;
      mem_en    <= nxt_en;
      mem_we    <= nxt_we;
      mem_addr  <= nxt_addr;
      mem_wdata <= nxt_wdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a behavioural sync RAM.
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic wr_req = 1'b0, rd_req = 1'b0;
  logic [15:0] wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic wr_ack, rd_valid, err, busy, mem_en, mem_we;
  logic [31:0] rd_data, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] mem_addr;
  logic [31:0] ram [64];
  int checks = 0, errors = 0;
  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .err(err), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[5:0]];
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic wait_rd(input string tag);
    int n = 0;
    while (!rd_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(rd_valid), 64'd1);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask
  logic we_seq [16];
  initial begin
    int idx, n, acks;
    logic [31:0] held;
    tick();
    check("rst_outs", {wr_ack, rd_valid, err, busy, mem_en, mem_we}, 64'd0);
    check("rst_data", {rd_data, mem_addr}, 64'd0);
    rst = 1'b1;
    tick();
    rd_req = 1'b1;
    rd_addr = 16'd3;
    tick();
    check("mid_read_en", {mem_en, busy}, 64'b11);
    #2 rst = 1'b0;
    #1 check("async_rst", {wr_ack, rd_valid, err, busy, mem_en, mem_we}, 64'd0);
    rd_req = 1'b0;
    tick();
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n += int'(rd_valid) + int'(busy);
    end
    check("post_rst_idle", 64'(n), 64'd0);
    wr_req = 1'b1;
    wr_addr = 16'd5;
    wr_data = 32'hDEADBEEF;
    tick();
    check("wr_strobe", {wr_ack, err, mem_en, mem_we, 16'(mem_addr)}, {4'b1011, 16'd5});
    check("wr_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    wr_req = 1'b0;
    tick();
    check("wr_idle", {wr_ack, busy, mem_en}, 64'd0);
    rd_req = 1'b1;
    rd_addr = 16'd5;
    tick();
    check("rd_strobe", {mem_en, mem_we, rd_valid, 16'(mem_addr)}, {3'b100, 16'd5});
    rd_req = 1'b0;
    tick();
    check("rd_wait", {rd_valid, mem_en, busy}, 64'b001);
    tick();
    check("rd_val", {rd_valid, err, rd_data}, {2'b10, 32'hDEADBEEF});
    tick();
    check("rd_held", {rd_valid, busy, rd_data}, {2'b00, 32'hDEADBEEF});
    do_reset();
    wr_addr = 16'd10;
    wr_data = 32'h12340000;
    rd_addr = 16'd11;
    wr_req = 1'b1;
    rd_req = 1'b1;
    idx = 0;
    n = 0;
`ifdef ARB_WRITE_PRIORITY_EN
    while (idx < 8 && n < 100) begin
      tick();
      n++;
      if (mem_en) begin
        we_seq[idx] = mem_we;
        idx++;
      end
    end
    check("prio_count", 64'(idx), 64'd8);
    for (int i = 0; i < 8; i++) check($sformatf("prio_we%0d", i), 64'(we_seq[i]), 64'd1);
    wr_req = 1'b0;
    wait_rd("prio_read_after");
    rd_req = 1'b0;
`else
    while (idx < 16 && n < 100) begin
      tick();
      n++;
      if (mem_en) begin
        we_seq[idx] = mem_we;
        idx++;
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    check("rr_count", 64'(idx), 64'd16);
    for (int i = 0; i < 16; i++) check($sformatf("rr_we%0d", i), 64'(we_seq[i]), 64'(i % 2 == 0));
`endif
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    check("drain", 64'(busy), 64'd0);
    wr_req = 1'b1;
    wr_addr = 16'd36;
    wr_data = 32'h55555555;
    tick();
    check("wr_oor", {wr_ack, err, mem_en, busy}, 64'b1101);
    wr_req = 1'b0;
    tick();
    check("wr_oor_done", {wr_ack, err, busy}, 64'd0);
    rd_req = 1'b1;
    rd_addr = 16'hFFFF;
    tick();
    check("rd_oor", {rd_valid, err, mem_en, rd_data}, {3'b110, 32'd0});
    rd_req = 1'b0;
    tick();
    wr_req = 1'b1;
    wr_addr = 16'd35;
    wr_data = 32'hCAFEF00D;
    tick();
    check("wr_35", {wr_ack, err, mem_en, mem_we, 16'(mem_addr)}, {4'b1011, 16'd35});
    wr_req = 1'b0;
    tick();
    rd_req = 1'b1;
    rd_addr = 16'd35;
    wait_rd("rd_35_valid");
    check("rd_35_data", {err, rd_data}, {1'b0, 32'hCAFEF00D});
    rd_req = 1'b0;
    tick();
    rd_req = 1'b1;
    rd_addr = 16'd5;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    check("rd_dropped", {rd_valid, rd_data}, {1'b1, 32'hDEADBEEF});
    tick();
    wr_req = 1'b1;
    wr_addr = 16'd7;
    wr_data = 32'hAAAA0001;
    acks = 0;
    held = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wr_ack) begin
        acks++;
        held = mem_wdata;
      end
      if (i == 0) wr_data = 32'hAAAA0002;
      if (i == 2) wr_req = 1'b0;
    end
    check("held_req_acks", 64'(acks), 64'd2);
    check("held_req_data", 64'(held), 64'hAAAA0002);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
